// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sp_op encodings, default SP constants and address-width helper
package regfile_pkg;
    typedef enum logic [1:0] {
        SP_NONE = 2'b00,
        SP_PUSH = 2'b01,
        SP_POP  = 2'b10
    } sp_op_e;
    localparam int          DEF_SP_IDX   = 13;
    localparam logic [15:0] DEF_SP_RESET = 16'h0080;
    function automatic int addr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write, scoreboard, stack and read-port bundle of the register file
interface regfile_mp_if import regfile_pkg::*; #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 3,
    localparam int AW      = addr_w(NUM_REGS)
);
    logic                     we0;
    logic [AW-1:0]            waddr0;
    logic [DATA_W-1:0]        wdata0;
    logic                     we1;
    logic [AW-1:0]            waddr1;
    logic [DATA_W-1:0]        wdata1;
    logic                     set_busy;
    logic [AW-1:0]            set_addr;
    logic [1:0]               sp_op;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [DATA_W-1:0]        sp_out;
    modport master (
        output we0, waddr0, wdata0, we1, waddr1, wdata1, set_busy, set_addr, sp_op, rd_addr,
        input  rd_data, rd_busy, sp_out
    );
    modport slave (
        input  we0, waddr0, wdata0, we1, waddr1, wdata1, set_busy, set_addr, sp_op, rd_addr,
        output rd_data, rd_busy, sp_out
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register load-pending bits with registered per-port lookup
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 3,
    localparam int AW      = addr_w(NUM_REGS)
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 i_set,
    input  logic [AW-1:0]        i_set_addr,
    input  logic                 i_clr,
    input  logic [AW-1:0]        i_clr_addr,
    input  logic [NUM_RD*AW-1:0] i_rd_addr,
    output logic [NUM_RD-1:0]    o_rd_busy
);
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [NUM_RD-1:0]   r_rd_busy;
    // set applied after clear so back-to-back loads to one register stay pending
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr) w_busy_nxt[i_clr_addr] = 1'b0;
        if (i_set) w_busy_nxt[i_set_addr] = 1'b1;
    end
    always_ff @(posedge clock) begin
        r_busy <= rst ? '0 : w_busy_nxt;
        for (int i = 0; i < NUM_RD; i++)
            r_rd_busy[i] <= rst ? 1'b0 : w_busy_nxt[i_rd_addr[i*AW +: AW]];
    end
    assign o_rd_busy = r_rd_busy;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with bypass, two write ports, SP push/pop and busy scoreboard
module regfile_mp import regfile_pkg::*; #(
    parameter int                DATA_W   = 16,
    parameter int                NUM_REGS = 16,
    parameter int                NUM_RD   = 3,
    parameter int                SP_IDX   = DEF_SP_IDX,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(DEF_SP_RESET),
    parameter bit                BYPASS   = 1'b1
) (
    input logic         clock,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int AW = addr_w(NUM_REGS);
    logic [DATA_W-1:0]        r_regs [NUM_REGS];
    logic [DATA_W-1:0]        w_nxt  [NUM_REGS];
    logic [DATA_W-1:0]        w_sp_nxt;
    logic [NUM_RD*DATA_W-1:0] r_rd_data;
    // w_nxt is the post-edge contents: we1 over we0 over SP arithmetic
    always_comb begin
        w_sp_nxt = bus.sp_op == SP_PUSH ? r_regs[SP_IDX] - DATA_W'(1) :
                   bus.sp_op == SP_POP  ? r_regs[SP_IDX] + DATA_W'(1) : r_regs[SP_IDX];
        for (int r = 0; r < NUM_REGS; r++)
            w_nxt[r] = bus.we1 && bus.waddr1 == AW'(r) ? bus.wdata1 :
                       bus.we0 && bus.waddr0 == AW'(r) ? bus.wdata0 :
                       r == SP_IDX                     ? w_sp_nxt   : r_regs[r];
    end
    always_ff @(posedge clock) begin
        for (int r = 0; r < NUM_REGS; r++)
            r_regs[r] <= rst ? (r == SP_IDX ? SP_RESET : '0) : w_nxt[r];
        for (int i = 0; i < NUM_RD; i++)
            r_rd_data[i*DATA_W +: DATA_W] <= rst    ? '0 :
                                             BYPASS ? w_nxt[bus.rd_addr[i*AW +: AW]] :
                                                      r_regs[bus.rd_addr[i*AW +: AW]];
    end
    regfile_scoreboard #(.NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD)) u_sb (
        .clock     (clock),
        .rst       (rst),
        .i_set     (bus.set_busy),
        .i_set_addr(bus.set_addr),
        .i_clr     (bus.we1),
        .i_clr_addr(bus.waddr1),
        .i_rd_addr (bus.rd_addr),
        .o_rd_busy (bus.rd_busy)
    );
    assign bus.rd_data = r_rd_data;
    assign bus.sp_out  = r_regs[SP_IDX];
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven check of bypassing and non-bypassing register files on shared stimulus
module tb_regfile_mp;
    logic clock = 1'b0;
    logic rst;
    always #5 clock = ~clock;
    regfile_mp_if b1 ();
    regfile_mp_if b0 ();
    regfile_mp #(.BYPASS(1'b1)) dut1 (.clock(clock), .rst(rst), .bus(b1.slave));
    regfile_mp #(.BYPASS(1'b0)) dut0 (.clock(clock), .rst(rst), .bus(b0.slave));
    assign b0.we0      = b1.we0;
    assign b0.waddr0   = b1.waddr0;
    assign b0.wdata0   = b1.wdata0;
    assign b0.we1      = b1.we1;
    assign b0.waddr1   = b1.waddr1;
    assign b0.wdata1   = b1.wdata1;
    assign b0.set_busy = b1.set_busy;
    assign b0.set_addr = b1.set_addr;
    assign b0.sp_op    = b1.sp_op;
    assign b0.rd_addr  = b1.rd_addr;
    typedef struct packed {
        logic        rst;
        logic        we0;
        logic [3:0]  wa0;
        logic [15:0] wd0;
        logic        we1;
        logic [3:0]  wa1;
        logic [15:0] wd1;
        logic        sb;
        logic [3:0]  sa;
        logic [1:0]  sp;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [2:0]  busy;
        logic [15:0] spe;
        logic [15:0] d0_nb;
    } vec_t;
    int total = 0;
    int bad = 0;
    vec_t vt [17];
    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask
    task automatic apply(input vec_t v);
        rst         = v.rst;
        b1.we0      = v.we0;
        b1.waddr0   = v.wa0;
        b1.wdata0   = v.wd0;
        b1.we1      = v.we1;
        b1.waddr1   = v.wa1;
        b1.wdata1   = v.wd1;
        b1.set_busy = v.sb;
        b1.set_addr = v.sa;
        b1.sp_op    = v.sp;
        b1.rd_addr  = {v.ra2, v.ra1, v.ra0};
        @(posedge clock);
        #1;
    endtask
    task automatic check(input string n, input vec_t v);
        chk({n, " d0"}, b1.rd_data[15:0], v.d0);
        chk({n, " d1"}, b1.rd_data[31:16], v.d1);
        chk({n, " d2"}, b1.rd_data[47:32], v.d2);
        chk({n, " busy"}, {13'd0, b1.rd_busy}, {13'd0, v.busy});
        chk({n, " sp"}, b1.sp_out, v.spe);
        chk({n, " nb_d0"}, b0.rd_data[15:0], v.d0_nb);
        chk({n, " nb_sp"}, b0.sp_out, v.spe);
    endtask
    initial begin
        vec_t v;
        //        rst we0 wa0 wd0       we1 wa1 wd1       sb sa sp     ra0 ra1 ra2 d0        d1        d2        busy    spe       d0_nb
        vt[0]  = '{0, 1, 3, 16'h1234, 0, 0, 16'h0000, 0, 0, 2'b00, 3, 7, 13, 16'h1234, 16'h0000, 16'h0080, 3'b000, 16'h0080, 16'h0000};
        vt[1]  = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2'b00, 3, 7, 13, 16'h1234, 16'h0000, 16'h0080, 3'b000, 16'h0080, 16'h1234};
        vt[2]  = '{0, 1, 5, 16'hAAAA, 1, 5, 16'h5555, 0, 0, 2'b00, 5, 7, 13, 16'h5555, 16'h0000, 16'h0080, 3'b000, 16'h0080, 16'h0000};
        vt[3]  = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2'b00, 5, 7, 13, 16'h5555, 16'h0000, 16'h0080, 3'b000, 16'h0080, 16'h5555};
        vt[4]  = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2'b01, 13, 7, 13, 16'h007F, 16'h0000, 16'h007F, 3'b000, 16'h007F, 16'h0080};
        vt[5]  = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2'b01, 13, 7, 13, 16'h007E, 16'h0000, 16'h007E, 3'b000, 16'h007E, 16'h007F};
        vt[6]  = '{0, 1, 13, 16'h0000, 0, 0, 16'h0000, 0, 0, 2'b10, 13, 7, 13, 16'h0000, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h007E};
        vt[7]  = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2'b01, 13, 7, 13, 16'hFFFF, 16'h0000, 16'hFFFF, 3'b000, 16'hFFFF, 16'h0000};
        vt[8]  = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2'b10, 13, 7, 13, 16'h0000, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'hFFFF};
        vt[9]  = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 7, 2'b00, 7, 7, 2, 16'h0000, 16'h0000, 16'h0000, 3'b011, 16'h0000, 16'h0000};
        vt[10] = '{0, 0, 0, 16'h0000, 1, 7, 16'h00FF, 1, 7, 2'b00, 7, 7, 2, 16'h00FF, 16'h00FF, 16'h0000, 3'b011, 16'h0000, 16'h0000};
        vt[11] = '{0, 0, 0, 16'h0000, 1, 7, 16'h00FF, 0, 0, 2'b00, 7, 7, 2, 16'h00FF, 16'h00FF, 16'h0000, 3'b000, 16'h0000, 16'h00FF};
        vt[12] = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2, 2'b11, 7, 7, 2, 16'h00FF, 16'h00FF, 16'h0000, 3'b100, 16'h0000, 16'h00FF};
        vt[13] = '{0, 1, 2, 16'h2222, 0, 0, 16'h0000, 0, 0, 2'b00, 7, 7, 2, 16'h00FF, 16'h00FF, 16'h2222, 3'b100, 16'h0000, 16'h00FF};
        vt[14] = '{0, 0, 0, 16'h0000, 1, 2, 16'hBEEF, 1, 2, 2'b00, 7, 7, 2, 16'h00FF, 16'h00FF, 16'hBEEF, 3'b100, 16'h0000, 16'h00FF};
        vt[15] = '{1, 1, 2, 16'h1111, 0, 0, 16'h0000, 1, 4, 2'b01, 4, 7, 2, 16'h0000, 16'h0000, 16'h0000, 3'b000, 16'h0080, 16'h0000};
        vt[16] = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2'b00, 4, 7, 2, 16'h0000, 16'h0000, 16'h0000, 3'b000, 16'h0080, 16'h0000};
        v = '0;
        v.rst = 1'b1;
        v.spe = 16'h0080;
        apply(v);
        check("reset", v);
        for (int a = 0; a < 16; a++) begin
            v = '0;
            v.ra0 = 4'(a);
            v.ra1 = 4'(a);
            v.ra2 = 4'(a);
            v.d0 = (a == 13) ? 16'h0080 : 16'h0000;
            v.d1 = v.d0;
            v.d2 = v.d0;
            v.d0_nb = v.d0;
            v.spe = 16'h0080;
            apply(v);
            check($sformatf("rdall r%0d", a), v);
        end
        for (int i = 0; i < 17; i++) begin
            apply(vt[i]);
            check($sformatf("vec%0d", i), vt[i]);
        end
        v = '0;
        v.sp = 2'b11;
        v.ra0 = 13;
        v.ra1 = 13;
        v.ra2 = 13;
        v.d0 = 16'h0080;
        v.d1 = 16'h0080;
        v.d2 = 16'h0080;
        v.spe = 16'h0080;
        v.d0_nb = 16'h0080;
        apply(v);
        check("sp_op11", v);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
